// File: rtl/oam_sprite_evaluator.sv
// OAM sprite evaluator: scans all 64 OAM entries for one scanline and
// copies the first MAX_SPRITES entries whose rows cover that line into the
// secondary sprite buffer, reporting count, overflow and sprite-0 hit.
module oam_sprite_evaluator #(
    parameter int MAX_SPRITES = 8,
    parameter int SLOT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        scanline,
    input  logic              sprite_size_16,
    output logic [5:0]        oam_read_addr,
    input  logic [31:0]       oam_read_data,
    output logic              sec_write_enable,
    output logic [SLOT_W-1:0] sec_write_addr,
    output logic [31:0]       sec_write_data,
    output logic [3:0]        sec_row,
    output logic              busy,
    output logic              done,
    output logic [SLOT_W:0]   sprite_count,
    output logic              overflow,
    output logic              sprite0_on_line
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [SLOT_W:0] COUNT_MAX = MAX_SPRITES[SLOT_W:0];
    localparam logic [SLOT_W:0] COUNT_ONE = (SLOT_W+1)'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [5:0]        idx_reg;
    logic [7:0]        line_reg;
    logic              size16_reg;
    logic              data_valid_reg;
    logic [5:0]        data_idx_reg;
    logic [SLOT_W:0]   count_reg;
    logic              overflow_reg;
    logic              sprite0_reg;
    logic              done_reg;
    logic              we_reg;
    logic [SLOT_W-1:0] waddr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        row_reg;

    logic              start_accept;
    logic [8:0]        diff;
    logic              match;
    logic              room;

    // Start is only honoured when no evaluation is running.
    assign start_accept = (state_reg == IDLE) && start;

    // Row offset of the current entry; a borrow (diff[8]) means the sprite
    // starts below this line, so there is no wrap-around from Y near 255.
    assign diff  = {1'b0, line_reg} - {1'b0, oam_read_data[7:0]};
    assign match = data_valid_reg && !diff[8]
                   && (diff[7:0] < (size16_reg ? 8'd16 : 8'd8));
    assign room  = count_reg < COUNT_MAX;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: 64 scan cycles then 2 drain cycles for the read
    // latency and the registered write of the last entry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (idx_reg == 6'd63) state_next = DRAIN;
            DRAIN:   if (idx_reg == 6'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs derived from the current state.
    always_comb begin
        busy          = (state_reg != IDLE);
        oam_read_addr = (state_reg == SCAN) ? idx_reg : 6'd0;
    end

    // Per-state cycle index, read-data pipeline tag and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg        <= 6'd0;
            data_valid_reg <= 1'b0;
            data_idx_reg   <= 6'd0;
            done_reg       <= 1'b0;
        end else begin
            if (state_reg == IDLE || state_next != state_reg) begin
                idx_reg <= 6'd0;
            end else begin
                idx_reg <= idx_reg + 6'd1;
            end
            data_valid_reg <= (state_reg == SCAN);
            data_idx_reg   <= idx_reg;
            done_reg       <= (state_reg == DRAIN) && (state_next == IDLE);
        end
    end

    // Line parameters captured with an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_reg   <= 8'd0;
            size16_reg <= 1'b0;
        end else if (start_accept) begin
            line_reg   <= scanline;
            size16_reg <= sprite_size_16;
        end
    end

    // Match bookkeeping: stored count, sticky overflow and sprite-0 hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            sprite0_reg  <= 1'b0;
        end else if (start_accept) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            sprite0_reg  <= 1'b0;
        end else if (match) begin
            if (room) begin
                count_reg <= count_reg + COUNT_ONE;
            end else begin
                overflow_reg <= 1'b1;
            end
            if (data_idx_reg == 6'd0) begin
                sprite0_reg <= 1'b1;
            end
        end
    end

    // Registered secondary-buffer write; all fields zero when not writing.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= 32'd0;
            row_reg   <= 4'd0;
        end else if (match && room) begin
            we_reg    <= 1'b1;
            waddr_reg <= count_reg[SLOT_W-1:0];
            wdata_reg <= oam_read_data;
            row_reg   <= diff[3:0];
        end else begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= 32'd0;
            row_reg   <= 4'd0;
        end
    end

    assign sec_write_enable = we_reg;
    assign sec_write_addr   = waddr_reg;
    assign sec_write_data   = wdata_reg;
    assign sec_row          = row_reg;
    assign done             = done_reg;
    assign sprite_count     = count_reg;
    assign overflow         = overflow_reg;
    assign sprite0_on_line  = sprite0_reg;

endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Testbench for oam_sprite_evaluator: directed line scenarios plus randomized
// OAM contents, checked every cycle against a cycle-numbered behavioural model.
module tb_oam_sprite_evaluator;

    localparam int MAXS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  scanline;
    logic        sprite_size_16;
    logic [5:0]  oam_read_addr;
    logic [31:0] oam_read_data;
    logic        sec_write_enable;
    logic [2:0]  sec_write_addr;
    logic [31:0] sec_write_data;
    logic [3:0]  sec_row;
    logic        busy;
    logic        done;
    logic [3:0]  sprite_count;
    logic        overflow;
    logic        sprite0_on_line;

    oam_sprite_evaluator #(.MAX_SPRITES(MAXS), .SLOT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .scanline        (scanline),
        .sprite_size_16  (sprite_size_16),
        .oam_read_addr   (oam_read_addr),
        .oam_read_data   (oam_read_data),
        .sec_write_enable(sec_write_enable),
        .sec_write_addr  (sec_write_addr),
        .sec_write_data  (sec_write_data),
        .sec_row         (sec_row),
        .busy            (busy),
        .done            (done),
        .sprite_count    (sprite_count),
        .overflow        (overflow),
        .sprite0_on_line (sprite0_on_line)
    );

    always #5 clk = ~clk;

    // OAM with one-cycle read latency
    logic [31:0] oam_mem [64];
    always @(posedge clk) oam_read_data <= oam_mem[oam_read_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mcyc = cycle number within the current evaluation (start cycle = 0),
    // -1 when idle without a done pulse this cycle.
    int          mcyc     = -1;
    bit          have_run = 1'b0;
    bit          m_match [64];
    int          m_rank  [64];
    logic [3:0]  m_row   [64];
    logic [31:0] m_data  [64];

    // captured writes / done pulses for the directed literal checks
    int          wr_n = 0;
    int          wr_cyc  [64];
    int          wr_addr [64];
    logic [31:0] wr_data [64];
    logic [3:0]  wr_row  [64];
    int          done_seen = 0;

    function automatic void build_model(input logic [7:0] line, input bit sz);
        int r;
        r = 0;
        for (int k = 0; k < 64; k++) begin
            int y;
            int d;
            y = int'(oam_mem[k][7:0]);
            d = int'(line) - y;
            m_match[k] = (d >= 0) && (d < (sz ? 16 : 8));
            m_row[k]   = 4'(d);
            m_data[k]  = oam_mem[k];
            m_rank[k]  = r;
            if (m_match[k]) r++;
        end
    endfunction

    task automatic compare_all();
        int c;
        int n;
        int k;
        bit ew;
        c = (mcyc == -1) ? (have_run ? 67 : 0) : mcyc;
        chk("busy", 32'(busy), 32'(mcyc >= 1 && mcyc <= 66));
        chk("done", 32'(done), 32'(mcyc == 67));
        chk("oam_read_addr", 32'(oam_read_addr), (mcyc >= 1 && mcyc <= 64) ? 32'(mcyc - 1) : 32'd0);
        k  = mcyc - 3;
        ew = (mcyc >= 3 && mcyc <= 66) && m_match[(k < 0) ? 0 : (k > 63 ? 63 : k)] && m_rank[(k < 0) ? 0 : (k > 63 ? 63 : k)] < MAXS;
        chk("sec_write_enable", 32'(sec_write_enable), 32'(ew));
        chk("sec_write_addr", 32'(sec_write_addr), ew ? 32'(m_rank[k]) : 32'd0);
        chk("sec_write_data", sec_write_data, ew ? m_data[k] : 32'd0);
        chk("sec_row", 32'(sec_row), ew ? 32'(m_row[k]) : 32'd0);
        n = 0;
        for (int j = 0; j < 64; j++) if (m_match[j] && (3 + j) <= c) n++;
        if (c == 0) n = 0;
        chk("sprite_count", 32'(sprite_count), 32'((n > MAXS) ? MAXS : n));
        chk("overflow", 32'(overflow), 32'(n > MAXS));
        chk("sprite0_on_line", 32'(sprite0_on_line), 32'(c >= 3 && m_match[0]));
    endtask

    // model update on each edge, then compare just after it
    always @(posedge clk) begin
        if (reset) begin
            mcyc     = -1;
            have_run = 1'b0;
        end else if (mcyc == -1 || mcyc == 67) begin
            if (start) begin
                build_model(scanline, sprite_size_16);
                mcyc     = 1;
                have_run = 1'b1;
                wr_n     = 0;
            end else begin
                mcyc = -1;
            end
        end else begin
            mcyc++;
        end
        #1;
        compare_all();
    end

    // capture of DUT activity for directed checks
    always @(negedge clk) begin
        if (sec_write_enable && wr_n < 64) begin
            wr_cyc[wr_n]  = mcyc;
            wr_addr[wr_n] = int'(sec_write_addr);
            wr_data[wr_n] = sec_write_data;
            wr_row[wr_n]  = sec_row;
            wr_n++;
        end
        if (done) done_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_oam();
        for (int k = 0; k < 64; k++) oam_mem[k] = {8'(k), 8'h00, 8'h00, 8'hFF};
    endtask

    // Launch one line; returns the cycle number (start cycle = 0) where done
    // was seen. 'now' launches in the current cycle (back-to-back with done);
    // 'poke' issues a spurious start mid-scan with a different scanline.
    task automatic run_line(input logic [7:0] line, input bit sz, input bit now,
                            input bit poke, output int dcyc);
        int pk;
        if (!now) @(negedge clk);
        scanline       = line;
        sprite_size_16 = sz;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcyc  = 1;
        pk    = $urandom_range(2, 60);
        while (!done && dcyc < 200) begin
            @(negedge clk);
            dcyc++;
            if (poke && dcyc == pk) begin
                start          = 1'b1;
                scanline       = 8'($urandom);
                sprite_size_16 = ~sz;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_within_bound", 32'(dcyc < 200), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int d0;
        reset          = 1'b1;
        start          = 1'b0;
        scanline       = 8'd0;
        sprite_size_16 = 1'b0;
        clear_oam();
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(sprite_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: no sprite on the line
        run_line(8'd100, 1'b0, 1'b0, 1'b0, dc);
        chk("t1_done_cycle", 32'(dc), 32'd67);
        chk("t1_writes", 32'(wr_n), 32'd0);
        chk("t1_count", 32'(sprite_count), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_sprite0", 32'(sprite0_on_line), 32'd0);

        // 2: single sprite, entry 5
        clear_oam();
        oam_mem[5] = {8'h40, 8'h00, 8'h21, 8'd96};
        run_line(8'd100, 1'b0, 1'b0, 1'b0, dc);
        chk("t2_writes", 32'(wr_n), 32'd1);
        chk("t2_write_cycle", 32'(wr_cyc[0]), 32'd8);
        chk("t2_write_addr", 32'(wr_addr[0]), 32'd0);
        chk("t2_write_data", wr_data[0], 32'h4000_2160);
        chk("t2_row", 32'(wr_row[0]), 32'd4);
        chk("t2_count", 32'(sprite_count), 32'd1);

        // 3: ten matches, overflow
        clear_oam();
        for (int k = 1; k <= 10; k++) oam_mem[k] = {8'(k), 8'h00, 8'h00, 8'd100};
        run_line(8'd100, 1'b0, 1'b0, 1'b0, dc);
        chk("t3_writes", 32'(wr_n), 32'd8);
        chk("t3_slot7_addr", 32'(wr_addr[7]), 32'd7);
        chk("t3_slot7_data", wr_data[7], {8'd8, 8'h00, 8'h00, 8'd100});
        chk("t3_count", 32'(sprite_count), 32'd8);
        chk("t3_overflow", 32'(overflow), 32'd1);

        // 4: sprite 0 with 16-row and 8-row sizes
        clear_oam();
        oam_mem[0] = {8'h00, 8'h00, 8'h00, 8'd90};
        run_line(8'd100, 1'b1, 1'b0, 1'b0, dc);
        chk("t4a_row", 32'(wr_row[0]), 32'd10);
        chk("t4a_sprite0", 32'(sprite0_on_line), 32'd1);
        chk("t4a_count", 32'(sprite_count), 32'd1);
        run_line(8'd100, 1'b0, 1'b0, 1'b0, dc);
        chk("t4b_sprite0", 32'(sprite0_on_line), 32'd0);
        chk("t4b_count", 32'(sprite_count), 32'd0);

        // 5: no wrap near Y=255; Y=0 on line 0
        clear_oam();
        oam_mem[3] = {8'h00, 8'h00, 8'h00, 8'd250};
        run_line(8'd2, 1'b1, 1'b0, 1'b0, dc);
        chk("t5a_count", 32'(sprite_count), 32'd0);
        oam_mem[3] = {8'h00, 8'h00, 8'h00, 8'd0};
        run_line(8'd0, 1'b0, 1'b0, 1'b0, dc);
        chk("t5b_count", 32'(sprite_count), 32'd1);
        chk("t5b_row", 32'(wr_row[0]), 32'd0);

        // 6: reset in cycle 30 of a scan with matches pending
        for (int k = 0; k < 64; k++) oam_mem[k] = {8'(k), 8'h00, 8'h00, 8'd100};
        @(negedge clk);
        scanline       = 8'd100;
        sprite_size_16 = 1'b0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy_after_reset", 32'(busy), 32'd0);
        d0 = done_seen;
        wr_n = 0;
        repeat (80) @(negedge clk);
        chk("t6_no_done", 32'(done_seen - d0), 32'd0);
        chk("t6_no_writes", 32'(wr_n), 32'd0);
        run_line(8'd100, 1'b0, 1'b0, 1'b0, dc);
        chk("t6_rerun_done_cycle", 32'(dc), 32'd67);
        chk("t6_rerun_overflow", 32'(overflow), 32'd1);

        // randomized lines; some with a spurious mid-scan start, some
        // launched back-to-back in the done cycle
        for (int t = 0; t < 30; t++) begin
            logic [7:0] line;
            bit         sz;
            int         dens;
            line = 8'($urandom);
            sz   = 1'($urandom_range(0, 1));
            dens = $urandom_range(0, 6);
            for (int k = 0; k < 64; k++) begin
                logic [31:0] e;
                int          off;
                e = $urandom;
                if ($urandom_range(0, 9) < dens) begin
                    off    = $urandom_range(0, 17);
                    e[7:0] = 8'(int'(line) - off);
                end else if ($urandom_range(0, 3) == 0) begin
                    e[7:0] = 8'($urandom_range(240, 255));
                end
                oam_mem[k] = e;
            end
            run_line(line, sz, (t % 4 == 3), 1'($urandom_range(0, 1)), dc);
            chk("rand_done_cycle", 32'(dc), 32'd67);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
